seq_divider: RTL

- Multi-cycle N-bit integer divider for the RISC-V M-extension datapath. It is the inverse-direction companion to the combinational ripple adder.
- Computes quotient or remainder by restoring division, one trial subtraction per clock, so the long carry chain never sits in one cycle.
- Sits beside the ALU in EX. The pipeline stalls while busy and captures result on done.
- Supports DIV, DIVU, REM and REMU with RISC-V divide-by-zero and overflow semantics.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_fa.sv | 16 +
 rtl/div_trial_sub.sv | 28 ++
 rtl/seq_divider.sv | 107 ++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared encodings for the multi-cycle divider: RISC-V funct3[1:0] op codes,
// FSM states and the iteration-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  // Counter runs N-1 down to 0, so $clog2(N) bits are enough.
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/div_fa.sv
// One-bit full-adder cell used to build ripple carry chains.
module div_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic w_p;

  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & w_p);

endmodule

// File: rtl/div_trial_sub.sv
// W-bit ripple subtractor: a + ~b + 1 through a chain of full-adder cells.
// o_borrow is high when b > a (unsigned).
module div_trial_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  logic [W:0] w_c;

  assign w_c[0] = 1'b1;

  for (genvar g = 0; g < W; g++) begin : g_bit
    div_fa u_fa (
      .i_a  (i_a[g]),
      .i_b  (~i_b[g]),
      .i_ci (w_c[g]),
      .o_s  (o_diff[g]),
      .o_co (w_c[g+1])
    );
  end

  assign o_borrow = ~w_c[W];

endmodule

// File: rtl/seq_divider.sv
// Restoring divider for DIV/DIVU/REM/REMU: one trial subtraction per clock,
// fixed N+2 cycle latency from start to the done pulse.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = cnt_width(N);

  div_state_e    r_state;
  logic          r_signed, r_is_rem, r_div0, r_neg_q, r_neg_r, r_done;
  logic [N-1:0]  r_dvd, r_dsr, r_quo, r_rem, r_result;
  logic [CW-1:0] r_cnt;

  logic          w_sgn_in;
  logic [N-1:0]  w_dvd_mag, w_dsr_mag;
  logic [N:0]    w_sh, w_diff;
  logic          w_borrow, w_ge;
  logic [N-1:0]  w_q_fix, w_r_fix, w_fix;

  assign w_sgn_in  = ~op[0];
  assign w_dvd_mag = (w_sgn_in && dividend[N-1]) ? -dividend : dividend;
  assign w_dsr_mag = (w_sgn_in && divisor[N-1])  ? -divisor  : divisor;

  // Remainder stays below the divisor, so its N+1-th bit only exists
  // transiently after the shift and is never stored.
  assign w_sh = {r_rem, r_quo[N-1]};

  div_trial_sub #(.W(N+1)) u_trial (
    .i_a      (w_sh),
    .i_b      ({1'b0, r_dsr}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  assign w_ge = ~w_borrow & ~w_diff[N];

  assign w_q_fix = (r_signed && r_neg_q) ? -r_quo : r_quo;
  assign w_r_fix = (r_signed && r_neg_r) ? -r_rem : r_rem;
  assign w_fix   = r_div0   ? (r_is_rem ? r_dvd : '1)
                            : (r_is_rem ? w_r_fix : w_q_fix);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_signed <= 1'b0;
      r_is_rem <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_dvd    <= '0;
      r_dsr    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_signed <= w_sgn_in;
            r_is_rem <= op[1];
            r_div0   <= (divisor == '0);
            r_neg_q  <= dividend[N-1] ^ divisor[N-1];
            r_neg_r  <= dividend[N-1];
            r_dvd    <= dividend;
            r_dsr    <= w_dsr_mag;
            r_quo    <= w_dvd_mag;
            r_rem    <= '0;
            r_cnt    <= CW'(N-1);
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_diff[N-1:0] : w_sh[N-1:0];
          r_quo <= {r_quo[N-2:0], w_ge};
          if (r_cnt == '0) r_state <= FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        FIX: begin
          r_result <= w_fix;
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule
